// File: rtl/relogio_pkg.sv
// Shared types and limits for the clock/adjust controller.
package relogio_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'b00,
        AJ_SEG  = 2'b01,
        AJ_MIN  = 2'b10,
        AJ_HORA = 2'b11
    } modo_t;

    localparam int unsigned CAMPO_W = 6;

    localparam logic [CAMPO_W-1:0] MAX_SEG  = 6'd59;
    localparam logic [CAMPO_W-1:0] MAX_MIN  = 6'd59;
    localparam logic [CAMPO_W-1:0] MAX_HORA = 6'd23;

    // Increment a time field, wrapping to zero past its maximum.
    function automatic logic [CAMPO_W-1:0] inc_wrap(input logic [CAMPO_W-1:0] valor,
                                                    input logic [CAMPO_W-1:0] maximo);
        return (valor == maximo) ? '0 : valor + CAMPO_W'(1);
    endfunction

endpackage

// File: rtl/relogio_ajuste_ctrl_if.sv
// Time/mode bus: the controller writes it, the display/blink path reads it.
interface relogio_ajuste_ctrl_if;
    import relogio_pkg::*;

    logic [CAMPO_W-1:0] segundos;
    logic [CAMPO_W-1:0] minutos;
    logic [CAMPO_W-1:0] horas;
    modo_t              modo_ajuste;

    modport master (output segundos, minutos, horas, modo_ajuste);
    modport slave  (input  segundos, minutos, horas, modo_ajuste);

endinterface

// File: rtl/relogio_ajuste_ctrl_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, press pulse.
// pulse_c is high in the cycle whose closing edge flips the debounced level 0->1.
module relogio_ajuste_ctrl_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse_c
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             last_c;

    // Final disagreeing sample of the stability window.
    assign last_c  = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign pulse_c = sync2 && !level && last_c;

    // Synchronize, then accept a new level only after an unbroken run of disagreement.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (last_c) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/relogio_ajuste_ctrl.sv
// HH:MM:SS time keeper with a 4-state adjust FSM driven by two push-buttons.
// Optional auto-exit from adjust after TIMEOUT_S idle seconds: define AJUSTE_TIMEOUT_EN.
module relogio_ajuste_ctrl
    import relogio_pkg::*;
#(
    parameter int unsigned CLK_FREQ        = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
`ifdef AJUSTE_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_S       = 10
`endif
) (
    input  logic                         clk_100MHz,
    input  logic                         reset,
    input  logic                         btn_modo,
    input  logic                         btn_inc,
    relogio_ajuste_ctrl_if.master        bus
);

    localparam int unsigned TICK_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
`ifdef AJUSTE_TIMEOUT_EN
    localparam int unsigned TO_W   = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;
`endif

    logic               modo_c;
    logic               inc_c;
    logic               tick_c;
    logic [TICK_W-1:0]  tick_cnt;
    logic [CAMPO_W-1:0] cont_seg;
    logic [CAMPO_W-1:0] cont_min;
    logic [CAMPO_W-1:0] cont_hora;
    modo_t              estado;
`ifdef AJUSTE_TIMEOUT_EN
    logic [TO_W-1:0]    to_cnt;
`endif

    relogio_ajuste_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_modo (
        .clk     (clk_100MHz),
        .reset   (reset),
        .btn     (btn_modo),
        .pulse_c (modo_c)
    );

    relogio_ajuste_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
        .clk     (clk_100MHz),
        .reset   (reset),
        .btn     (btn_inc),
        .pulse_c (inc_c)
    );

    assign tick_c = (tick_cnt == TICK_W'(CLK_FREQ - 1));

    // Tick divider, adjust FSM and time fields; a mode pulse always wins over inc.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            tick_cnt  <= '0;
            cont_seg  <= '0;
            cont_min  <= '0;
            cont_hora <= '0;
            estado    <= NORMAL;
`ifdef AJUSTE_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            tick_cnt <= tick_c ? '0 : tick_cnt + TICK_W'(1);
            if (estado == NORMAL) begin
                if (tick_c) begin
                    if (cont_seg == MAX_SEG) begin
                        cont_seg <= '0;
                        if (cont_min == MAX_MIN) begin
                            cont_min  <= '0;
                            cont_hora <= inc_wrap(cont_hora, MAX_HORA);
                        end else begin
                            cont_min <= cont_min + CAMPO_W'(1);
                        end
                    end else begin
                        cont_seg <= cont_seg + CAMPO_W'(1);
                    end
                end
                if (modo_c) begin
                    estado <= AJ_SEG;
`ifdef AJUSTE_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
            end else if (modo_c) begin
                estado <= modo_t'(2'(estado + 2'd1));
                if (estado == AJ_HORA) begin
                    tick_cnt <= '0;
                end
`ifdef AJUSTE_TIMEOUT_EN
                to_cnt <= '0;
`endif
            end else if (inc_c) begin
                case (estado)
                    AJ_SEG:  cont_seg  <= inc_wrap(cont_seg, MAX_SEG);
                    AJ_MIN:  cont_min  <= inc_wrap(cont_min, MAX_MIN);
                    AJ_HORA: cont_hora <= inc_wrap(cont_hora, MAX_HORA);
                    default: ;
                endcase
`ifdef AJUSTE_TIMEOUT_EN
                to_cnt <= '0;
`endif
            end
`ifdef AJUSTE_TIMEOUT_EN
            else if (tick_c) begin
                if (to_cnt == TO_W'(TIMEOUT_S - 1)) begin
                    estado   <= NORMAL;
                    tick_cnt <= '0;
                    to_cnt   <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end
`endif
        end
    end

    assign bus.segundos    = cont_seg;
    assign bus.minutos     = cont_min;
    assign bus.horas       = cont_hora;
    assign bus.modo_ajuste = estado;

endmodule

// File: tb/tb_relogio_ajuste_ctrl.sv
// Bench for relogio_ajuste_ctrl with CLK_FREQ=10, DEBOUNCE_CYCLES=4, TIMEOUT_S=3.
module tb_relogio_ajuste_ctrl;
    import relogio_pkg::*;

    logic clk_100MHz = 1'b0;
    logic reset      = 1'b1;
    logic btn_modo   = 1'b0;
    logic btn_inc    = 1'b0;

    relogio_ajuste_ctrl_if bus_if ();

    relogio_ajuste_ctrl #(
        .CLK_FREQ        (10),
        .DEBOUNCE_CYCLES (4)
`ifdef AJUSTE_TIMEOUT_EN
        ,
        .TIMEOUT_S       (3)
`endif
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .btn_modo   (btn_modo),
        .btn_inc    (btn_inc),
        .bus        (bus_if)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        string      nome;
        logic [5:0] seg;
        logic [5:0] min;
        logic [5:0] hora;
        logic [1:0] modo;
        bit         so_modo;
    } exp_t;

    typedef struct {
        bit m;
        bit i;
        int n;
        int s;
        int mi;
        int h;
        int md;
    } vec_t;

    exp_t sb[$];
    vec_t tabela[13];
    int   total = 0;
    int   bad   = 0;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    task automatic aplica_reset();
        reset    = 1'b1;
        btn_modo = 1'b0;
        btn_inc  = 1'b0;
        cyc(2);
        reset    = 1'b0;
    endtask

    task automatic press(input bit m, input bit i);
        btn_modo = m;
        btn_inc  = i;
        cyc(8);
        btn_modo = 1'b0;
        btn_inc  = 1'b0;
        cyc(8);
    endtask

    task automatic esperar(input string nome, input int s, input int mi, input int h,
                           input int md, input bit so_modo);
        exp_t e;
        e.nome    = nome;
        e.seg     = 6'(s);
        e.min     = 6'(mi);
        e.hora    = 6'(h);
        e.modo    = 2'(md);
        e.so_modo = so_modo;
        sb.push_back(e);
    endtask

    task automatic conferir();
        exp_t       e;
        logic [1:0] md;
        bit         erro;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard: empty queue at check %0d", total);
        end else begin
            e    = sb.pop_front();
            md   = bus_if.modo_ajuste;
            erro = e.so_modo ? (md !== e.modo)
                             : ({bus_if.horas, bus_if.minutos, bus_if.segundos, md}
                                !== {e.hora, e.min, e.seg, e.modo});
            if (erro) begin
                bad++;
                $display("FAIL %s: got %0d:%0d:%0d modo=%0d, expected %0d:%0d:%0d modo=%0d%s",
                         e.nome, bus_if.horas, bus_if.minutos, bus_if.segundos, md,
                         e.hora, e.min, e.seg, e.modo, e.so_modo ? " (modo only)" : "");
            end
        end
    endtask

    task automatic checa(input string nome, input int s, input int mi, input int h,
                         input int md, input bit so_modo);
        esperar(nome, s, mi, h, md, so_modo);
        conferir();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        //            m  i  n   seg min hora modo
        tabela[0]  = '{1, 0, 1,  0,  0,  0, 1};
        tabela[1]  = '{0, 1, 59, 59, 0,  0, 1};
        tabela[2]  = '{0, 1, 1,  0,  0,  0, 1};
        tabela[3]  = '{0, 1, 59, 59, 0,  0, 1};
        tabela[4]  = '{1, 0, 1,  59, 0,  0, 2};
        tabela[5]  = '{0, 1, 59, 59, 59, 0, 2};
        tabela[6]  = '{0, 1, 2,  59, 1,  0, 2};
        tabela[7]  = '{0, 0, 10, 59, 1,  0, 2};
        tabela[8]  = '{0, 1, 58, 59, 59, 0, 2};
        tabela[9]  = '{1, 0, 1,  59, 59, 0, 3};
        tabela[10] = '{0, 1, 24, 59, 59, 0, 3};
        tabela[11] = '{0, 1, 23, 59, 59, 23, 3};
        tabela[12] = '{0, 0, 10, 59, 59, 23, 3};

        // Reset state and first second after release.
        aplica_reset();
        checa("reset", 0, 0, 0, 0, 0);
        cyc(9);
        checa("pre_first_tick", 0, 0, 0, 0, 0);
        cyc(1);
        checa("first_tick", 1, 0, 0, 0, 0);

        // 600 idle cycles = 60 seconds.
        aplica_reset();
        cyc(600);
        checa("idle_600", 0, 1, 0, 0, 0);

        // Table-driven adjust sequence from 00:00:00.
        aplica_reset();
        foreach (tabela[k]) begin
            esperar($sformatf("vec%0d", k), tabela[k].s, tabela[k].mi, tabela[k].h,
                    tabela[k].md, 0);
            if (!tabela[k].m && !tabela[k].i) begin
                cyc(tabela[k].n);
            end else begin
                for (int p = 0; p < tabela[k].n; p++) press(tabela[k].m, tabela[k].i);
            end
            conferir();
        end

        // Leave AJ_HORA at 23:59:59: tick counter restarts, rollover 10 cycles later.
        btn_modo = 1'b1;
        cyc(5);
        checa("exit_pre_pulse", 59, 59, 23, 3, 0);
        cyc(1);
        checa("exit_to_normal", 59, 59, 23, 0, 0);
        cyc(9);
        checa("pre_rollover", 59, 59, 23, 0, 0);
        cyc(1);
        checa("rollover", 0, 0, 0, 0, 0);
        btn_modo = 1'b0;
        cyc(8);

        // Short glitch is rejected; a long hold gives exactly one step.
        aplica_reset();
        btn_modo = 1'b1;
        cyc(3);
        btn_modo = 1'b0;
        cyc(10);
        checa("glitch", 0, 0, 0, 0, 1);
        btn_modo = 1'b1;
        cyc(5);
        checa("hold_before", 0, 0, 0, 0, 1);
        cyc(1);
        checa("hold_step", 0, 0, 0, 1, 1);
        cyc(4);
        btn_modo = 1'b0;
        cyc(8);
        checa("hold_single", 0, 0, 0, 1, 1);

        // Mode and inc together: mode wins, inc dropped.
        aplica_reset();
        press(1, 0);
        checa("both_setup", 0, 0, 0, 1, 0);
        press(1, 1);
        checa("both_pressed", 0, 0, 0, 2, 0);

        // Idle in AJ_SEG: auto-exit only when the timeout feature is built.
        aplica_reset();
        press(1, 0);
        cyc(30);
`ifdef AJUSTE_TIMEOUT_EN
        checa("timeout", 0, 0, 0, 0, 1);
`else
        checa("no_timeout", 0, 0, 0, 1, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/relogio_ajuste_ctrl.md
Name: relogio_ajuste_ctrl

Overview:
Time-keeping and adjust controller that produces the segundos/minutos/horas/modo_ajuste bus consumed by the display/adjust-blink path. Debounces two raw push-buttons (mode, increment), runs a 4-state adjust FSM, and counts HH:MM:SS from a 1 Hz tick derived from the system clock. It is the writer of the time/mode interface; the display side is the reader.

Parameters:
CLK_FREQ, 100_000_000, clock cycles per second (1 Hz tick period)
DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronized samples needed to accept a button level change
TIMEOUT_S, 10, seconds without a press before adjust mode auto-exits (used only with AJUSTE_TIMEOUT_EN)

Ports:
clk_100MHz  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_modo  in  1  raw mode button, active-high, asynchronous to clock
btn_inc  in  1  raw increment button, active-high, asynchronous to clock
segundos  out  6  seconds 0..59, binary
minutos  out  6  minutes 0..59, binary
horas  out  6  hours 0..23, binary
modo_ajuste  out  2  00 normal, 01 adjust seconds, 10 adjust minutes, 11 adjust hours

Behaviour:
- Reset (sync, active-high): segundos=minutos=horas=0, modo_ajuste=00, tick counter=0, debounced levels=0, synchronizers=0, timeout counter=0. All outputs registered.
- Button path (per button): 2-FF synchronizer; debounced level flips only after synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles (any agreeing sample clears the count). Press pulse = 1 cycle on debounced 0->1; release produces nothing. Raw rise to pulse: 2+DEBOUNCE_CYCLES cycles. Holding yields exactly one pulse.
- Tick: counter 0..CLK_FREQ-1; tick=1 for one cycle when counter==CLK_FREQ-1, then wraps to 0. Counter runs in all modes.
- FSM states NORMAL(00) -> AJ_SEG(01) -> AJ_MIN(10) -> AJ_HORA(11) -> NORMAL, advancing one step per modo pulse; modo_ajuste = state encoding, updated on the edge the pulse is sampled.
- NORMAL: on tick, segundos++; 59->0 carries to minutos; minutos 59->0 carries to horas; horas 23->0. 23:59:59 -> 00:00:00 on one edge.
- AJ_*: time frozen (ticks ignored). inc pulse increments only the selected field, wrapping 59->0 (seg/min) or 23->0 (hora), no carry.
- Simultaneous modo and inc pulses in the same cycle: mode transition taken, inc discarded.
- AJ_HORA -> NORMAL transition clears tick counter to 0, so first advance occurs exactly CLK_FREQ cycles later.
- Tick coinciding with NORMAL->AJ_SEG transition: time advances once on that edge (NORMAL rules apply in the sampling cycle).
- Reset asserted mid-adjust or mid-debounce: returns to reset values next edge; pending presses lost.

Optional Feature:
AJUSTE_TIMEOUT_EN: when defined, a timeout counter counts ticks while in any AJ_* state, cleared on every modo/inc pulse and on entry to AJ_SEG; on reaching TIMEOUT_S ticks, FSM returns to NORMAL (tick counter cleared as above). Without the macro, adjust modes persist until modo pulses; no timeout counter is synthesized.

Decomposition:
- Package relogio_pkg: enum modo_t {NORMAL=2'b00, AJ_SEG=2'b01, AJ_MIN=2'b10, AJ_HORA=2'b11}; constants MAX_SEG=59, MAX_MIN=59, MAX_HORA=23.
- Sub-module debounce (synchronizer + stability counter + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated twice.

Test Plan (CLK_FREQ=10, DEBOUNCE_CYCLES=4, TIMEOUT_S=3):
- Reset then 600 cycles idle -> time 00:01:00, modo_ajuste=00; segundos first becomes 1 at cycle 10 after reset release.
- Preload 23:59:59 via adjust, return to NORMAL, wait 10 cycles -> 00:00:00 on a single edge.
- btn_modo glitch high 3 cycles -> no mode change; held 10 cycles -> exactly one step to 01, 6 cycles after rise.
- modo_ajuste=10, minutos=59, 2 inc presses -> minutos=1, horas and segundos unchanged, no carry; 30 idle cycles -> time unchanged.
- btn_modo and btn_inc raised on same cycle in AJ_SEG -> modo_ajuste=10, segundos unchanged.
- With AJUSTE_TIMEOUT_EN: enter AJ_SEG, idle 30 cycles -> modo_ajuste returns to 00; without macro -> stays 01.
